// File: rtl/layer3_input_packer_pkg.sv
// Shared constants and FSM encoding for the discriminator final-layer input bus.
// The element count and width are also used by the final-layer scorer so both
// ends of the flat bus agree on its width.
package layer3_input_packer_pkg;

  localparam int unsigned L3_N_ELEM      = 32;
  localparam int unsigned L3_DATA_W      = 16;
  localparam int unsigned L3_TIMEOUT_CYC = 4096;
  localparam int unsigned L3_VEC_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/layer3_input_packer_if.sv
// Bus between the upstream activation stream, the packer and the final-layer scorer.
//   in_valid/in_data/in_last/in_ready : element stream (valid/ready)
//   flat_out/start_out/consumer_done  : packed vector handoff to the scorer
//   busy/frame_err/timeout/vec_count  : status
// master = packer side, slave = upstream source plus scorer side.
interface layer3_input_packer_if
  import layer3_input_packer_pkg::*;
#(
  parameter int unsigned N_ELEM = L3_N_ELEM,
  parameter int unsigned DATA_W = L3_DATA_W
) ();

  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       in_last;
  logic                       in_ready;
  logic [N_ELEM*DATA_W-1:0]   flat_out;
  logic                       start_out;
  logic                       consumer_done;
  logic                       busy;
  logic                       frame_err;
  logic                       timeout;
  logic [L3_VEC_CNT_W-1:0]    vec_count;

  modport master (
    input  in_valid, in_data, in_last, consumer_done,
    output in_ready, flat_out, start_out, busy, frame_err, timeout, vec_count
  );

  modport slave (
    output in_valid, in_data, in_last, consumer_done,
    input  in_ready, flat_out, start_out, busy, frame_err, timeout, vec_count
  );

endinterface

// File: rtl/layer3_input_packer.sv
// Packs a stream of DATA_W-bit activations into an N_ELEM-wide flat vector,
// launches the final-layer scorer with a one-cycle start pulse and holds the
// vector until the scorer reports done (or the done watchdog expires).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : layer3_input_packer_if.master (stream in, flat vector out, status)
// Element i occupies flat_out[DATA_W*i +: DATA_W]; element 0 is in the LSBs.
module layer3_input_packer
  import layer3_input_packer_pkg::*;
#(
  parameter int unsigned N_ELEM      = L3_N_ELEM,
  parameter int unsigned DATA_W      = L3_DATA_W,
  parameter int unsigned TIMEOUT_CYC = L3_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  layer3_input_packer_if.master  bus
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned VC_W  = L3_VEC_CNT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  // Expiry fires in the TIMEOUT_CYC-th cycle of WAIT (counter starts at 0).
  localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit               WD_EN    = (TIMEOUT_CYC != 0);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [N_ELEM-1:0][DATA_W-1:0]   r_buf;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_wait_cnt;
  logic                            r_in_ready;
  logic                            r_start;
  logic                            r_busy;
  logic                            r_frame_err;
  logic                            r_timeout;
  logic [VC_W-1:0]                 r_vec_count;

  logic w_idx_last;
  logic w_accept;
  logic w_frame_err;
  logic w_wait_exit;
  logic w_expire;

  assign w_idx_last = (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer/event decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_frame_err = 1'b0;
    w_wait_exit = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept = 1'b1;
          if (w_idx_last || bus.in_last) begin
            w_state_nxt = ST_LAUNCH;
            // Short frame (last early) or long frame (full without last)
            w_frame_err = w_idx_last ^ bus.in_last;
          end
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes priority over a simultaneous watchdog expiry
        if (bus.consumer_done) begin
          w_wait_exit = 1'b1;
          w_state_nxt = ST_FILL;
        end else if (WD_EN && (r_wait_cnt == EXP_CNT)) begin
          w_expire    = 1'b1;
          w_wait_exit = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Datapath and registered outputs; outputs derive from next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= '0;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_in_ready  <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_FILL);
      r_start     <= (w_state_nxt == ST_LAUNCH);
      r_busy      <= (w_state_nxt != ST_FILL);
      r_frame_err <= w_frame_err;

      if (w_expire) begin
        r_timeout <= 1'b1;
      end

      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end

      // Buffer is cleared on re-entry to FILL so short frames leave zeros
      if (w_wait_exit) begin
        r_buf       <= '0;
        r_idx       <= '0;
        r_vec_count <= r_vec_count + VC_W'(1);
      end else if (w_accept) begin
        r_buf[r_idx] <= bus.in_data;
        if (w_state_nxt == ST_FILL) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.flat_out  = r_buf;
  assign bus.start_out = r_start;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
  assign bus.timeout   = r_timeout;
  assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_layer3_input_packer.sv
// Self-checking bench for layer3_input_packer. Two instances share the same
// stimulus: u_dut uses the default watchdog, u_dut_wd uses an 8-cycle watchdog
// and is only checked in the timeout sequence.
module tb_layer3_input_packer;
  import layer3_input_packer_pkg::*;

  localparam int unsigned NE = L3_N_ELEM;
  localparam int unsigned DW = L3_DATA_W;
  localparam int unsigned VW = NE * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          tb_valid = 1'b0;
  logic          tb_last  = 1'b0;
  logic          tb_done  = 1'b0;
  logic [DW-1:0] tb_data  = '0;

  layer3_input_packer_if a ();
  layer3_input_packer_if b ();

  assign a.in_valid = tb_valid;  assign b.in_valid = tb_valid;
  assign a.in_data  = tb_data;   assign b.in_data  = tb_data;
  assign a.in_last  = tb_last;   assign b.in_last  = tb_last;
  assign a.consumer_done = tb_done;
  assign b.consumer_done = tb_done;

  layer3_input_packer #(.TIMEOUT_CYC(L3_TIMEOUT_CYC)) u_dut (.clk(clk), .rst(rst), .bus(a));
  layer3_input_packer #(.TIMEOUT_CYC(8))              u_dut_wd (.clk(clk), .rst(rst), .bus(b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] vec;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  // Reference packing model: fed on every accepted element
  logic [NE-1:0][DW-1:0] m_vec = '0;
  int                    m_idx = 0;

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    logic        last;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every launch must match the oldest expected vector
  logic prev_start = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (a.start_out) begin
      chk("start_one_cycle", VW'(prev_start), '0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_start: got start expected none");
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_flat_out", a.flat_out, mon_e.vec);
        chk("sb_frame_err", VW'(a.frame_err), VW'(mon_e.err));
      end
    end
    prev_start = a.start_out;
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n = 0;
    tb_valid = 1'b1;
    tb_data  = d;
    tb_last  = last;
    @(negedge clk);
    while (!a.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!a.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_wait: got in_ready 0 expected 1 within 300 cycles");
      tb_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m_vec[m_idx] = d;
    if (m_idx == NE - 1 || last) begin
      sb_q.push_back('{vec: VW'(m_vec), err: ((m_idx == NE - 1) != last)});
      m_vec = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic idle();
    tb_valid = 1'b0;
    tb_last  = 1'b0;
  endtask

  task automatic pulse_done();
    tb_done = 1'b1;
    @(posedge clk);
    #1;
    tb_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  VW'(a.in_ready),  '0);
    chk({tag, "_flat_out"},  a.flat_out,       '0);
    chk({tag, "_start_out"}, VW'(a.start_out), '0);
    chk({tag, "_busy"},      VW'(a.busy),      '0);
    chk({tag, "_frame_err"}, VW'(a.frame_err), '0);
    chk({tag, "_timeout"},   VW'(a.timeout),   '0);
    chk({tag, "_vec_count"}, VW'(a.vec_count), '0);
  endtask

  vec_t                  tbl[4];
  logic [NE-1:0][DW-1:0] rv;

  initial begin
    tbl[0] = '{n: 5,  base: 16'hFFFF, step: 16'h0000, last: 1'b1, exp_err: 1'b1, exp_cnt: 16'd2};
    tbl[1] = '{n: 32, base: 16'h8000, step: 16'h0111, last: 1'b1, exp_err: 1'b0, exp_cnt: 16'd3};
    tbl[2] = '{n: 1,  base: 16'h7FFF, step: 16'h0000, last: 1'b1, exp_err: 1'b1, exp_cnt: 16'd4};
    tbl[3] = '{n: 32, base: 16'hA5A5, step: 16'h0000, last: 1'b1, exp_err: 1'b0, exp_cnt: 16'd5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", VW'(a.in_ready), VW'(1));

    // Normal frame 0x0001..0x0020 followed by 10 cycles of backpressure
    for (int i = 0; i < 32; i++) send(DW'(i + 1), i == 31);
    for (int i = 0; i < 32; i++) rv[i] = DW'(i + 1);
    chk("norm_start", VW'(a.start_out), VW'(1));
    chk("norm_busy", VW'(a.busy), VW'(1));
    chk("norm_frame_err", VW'(a.frame_err), '0);
    chk("norm_lsb_slice", VW'(a.flat_out[15:0]), VW'(16'h0001));
    chk("norm_msb_slice", VW'(a.flat_out[511:496]), VW'(16'h0020));
    tb_valid = 1'b1;
    tb_data  = 16'h5555;
    tb_last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", VW'(a.in_ready), '0);
      chk("bp_flat_hold", a.flat_out, VW'(rv));
      chk("bp_busy", VW'(a.busy), VW'(1));
    end
    chk("bp_vec_count_pre", VW'(a.vec_count), '0);
    pulse_done();
    idle();
    chk("done_vec_count", VW'(a.vec_count), VW'(1));
    chk("done_in_ready", VW'(a.in_ready), VW'(1));
    chk("done_busy", VW'(a.busy), '0);
    chk("done_buf_clear", a.flat_out, '0);

    // Table-driven frames
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < tbl[t].n; j++)
        send(DW'(int'(tbl[t].base) + j * int'(tbl[t].step)), tbl[t].last && (j == tbl[t].n - 1));
      idle();
      rv = '0;
      for (int j = 0; j < tbl[t].n; j++) rv[j] = DW'(int'(tbl[t].base) + j * int'(tbl[t].step));
      chk("tbl_start", VW'(a.start_out), VW'(1));
      chk("tbl_flat", a.flat_out, VW'(rv));
      chk("tbl_frame_err", VW'(a.frame_err), VW'(tbl[t].exp_err));
      repeat (2) @(posedge clk);
      #1;
      chk("tbl_err_pulse_end", VW'(a.frame_err), '0);
      pulse_done();
      chk("tbl_vec_count", VW'(a.vec_count), VW'(tbl[t].exp_cnt));
      chk("tbl_in_ready", VW'(a.in_ready), VW'(1));
    end

    // Long frame: 33rd element waits and becomes element 0 of the next vector
    for (int i = 0; i < 32; i++) send(DW'(16'h0200 + i), 1'b0);
    chk("long_start", VW'(a.start_out), VW'(1));
    chk("long_frame_err", VW'(a.frame_err), VW'(1));
    chk("long_in_ready", VW'(a.in_ready), '0);
    fork
      send(16'hBEEF, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("long_hold_ready", VW'(a.in_ready), '0);
        pulse_done();
      end
    join
    chk("long_vec_count", VW'(a.vec_count), VW'(6));
    chk("long_carry_elem0", VW'(a.flat_out[15:0]), VW'(16'hBEEF));
    for (int i = 1; i < 32; i++) send(DW'(16'h0300 + i), i == 31);
    idle();
    chk("carry_start", VW'(a.start_out), VW'(1));
    chk("carry_frame_err", VW'(a.frame_err), '0);
    // Done during LAUNCH must be ignored
    pulse_done();
    chk("launch_done_ignored_busy", VW'(a.busy), VW'(1));
    chk("launch_done_ignored_cnt", VW'(a.vec_count), VW'(6));
    pulse_done();
    chk("carry_vec_count", VW'(a.vec_count), VW'(7));

    // Watchdog expiry on the 8-cycle instance
    rst = 1'b1;
    m_vec = '0;
    m_idx = 0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) send(DW'(16'h0400 + i), i == 31);
    idle();
    chk("wd_start", VW'(b.start_out), VW'(1));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("wd_timeout_low", VW'(b.timeout), '0);
      chk("wd_busy", VW'(b.busy), VW'(1));
    end
    @(posedge clk);
    #1;
    chk("wd_timeout_set", VW'(b.timeout), VW'(1));
    chk("wd_busy_clear", VW'(b.busy), '0);
    chk("wd_in_ready", VW'(b.in_ready), VW'(1));
    chk("wd_vec_count", VW'(b.vec_count), VW'(1));
    chk("wd_default_busy", VW'(a.busy), VW'(1));
    chk("wd_default_timeout", VW'(a.timeout), '0);
    pulse_done();
    chk("fill_done_ignored", VW'(b.vec_count), VW'(1));
    chk("default_done_cnt", VW'(a.vec_count), VW'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("wd_timeout_sticky", VW'(b.timeout), VW'(1));

    // Reset mid-fill
    for (int i = 0; i < 12; i++) send(DW'(16'h0600 + i), 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    m_vec = '0;
    m_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", VW'(a.in_ready), VW'(1));
    chk("midrst_timeout_clr", VW'(b.timeout), '0);
    for (int i = 0; i < 32; i++) send(DW'(16'h0700 + i), i == 31);
    idle();
    chk("midrst_start", VW'(a.start_out), VW'(1));
    chk("midrst_elem0", VW'(a.flat_out[15:0]), VW'(16'h0700));
    @(posedge clk);
    #1;
    pulse_done();
    chk("midrst_vec_count", VW'(a.vec_count), VW'(1));

    @(posedge clk);
    #1;
    chk("sb_all_consumed", VW'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

endmodule
